// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: four requesters share one DATA_W-bit register through a
// round-robin arbiter. A granted requester writes the register during its
// grant cycle. Optional grant locking is enabled with the macro
// REG_SHARE_ARBITER_LOCK_EN.
//
// Ports:
//   clk     - clock; all state updates on its rising edge
//   reset   - synchronous active-high reset
//   req     - per-requester request (bit i = requester i)
//   we      - per-requester write enable, honoured only while granted
//   wdata   - write data, requester i drives [i*DATA_W +: DATA_W]
//   lock    - per-requester grant hold (present only with REG_SHARE_ARBITER_LOCK_EN)
//   gnt     - registered one-hot grant, zero when idle
//   busy    - registered, high exactly when gnt is non-zero
//   q       - registered shared register contents
//   wr_ack  - registered one-cycle write confirmation to the writer
module reg_share_arbiter #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [3:0]            we,
    input  logic [4*DATA_W-1:0]   wdata,
`ifdef REG_SHARE_ARBITER_LOCK_EN
    input  logic [3:0]            lock,
`endif
    output logic [3:0]            gnt,
    output logic                  busy,
    output logic [DATA_W-1:0]     q,
    output logic [3:0]            wr_ack
);

    // Counter tracks cycles already spent in the current grant (0..MAX_LOCK-1).
    localparam int unsigned CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    logic [1:0]          r_gidx;
    logic [1:0]          r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_gnt;
    logic                r_busy;
    logic [DATA_W-1:0]   r_q;
    logic [3:0]          r_ack;

    logic [3:0]          w_lock;
    logic                w_in_grant;
    logic                w_write;
    logic                w_hold;
    logic [1:0]          w_base;
    logic [1:0]          w_idx;
    logic [1:0]          w_win;
    logic                w_found;
    logic [DATA_W-1:0]   w_wdata;

    // Without the lock feature the hold path sees a constant zero and folds away.
`ifdef REG_SHARE_ARBITER_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 4'b0000;
`endif

    assign w_in_grant = (r_state == ST_GRANT);
    assign w_write    = w_in_grant && req[r_gidx] && we[r_gidx];
    assign w_hold     = w_in_grant && req[r_gidx] && w_lock[r_gidx]
                        && (r_cnt < CNT_W'(MAX_LOCK - 1));
    assign w_wdata    = wdata[32'(r_gidx) * DATA_W +: DATA_W];

    // A closing grant arbitrates from the pointer it is about to install.
    assign w_base = w_in_grant ? (r_gidx + 2'd1) : r_ptr;

    // Round-robin search: first set request scanning upward from w_base.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_idx = w_base + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // FSM, pointer, shared register and acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gidx  <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
            r_q     <= '0;
            r_ack   <= 4'b0000;
        end else begin
            r_ack <= w_write ? (4'b0001 << r_gidx) : 4'b0000;
            if (w_write) begin
                r_q <= w_wdata;
            end
            if (w_hold) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
                if (w_in_grant) begin
                    r_ptr <= r_gidx + 2'd1;
                end
                if (w_found) begin
                    r_state <= ST_GRANT;
                    r_gidx  <= w_win;
                    r_gnt   <= 4'b0001 << w_win;
                    r_busy  <= 1'b1;
                end else begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign gnt    = r_gnt;
    assign busy   = r_busy;
    assign q      = r_q;
    assign wr_ack = r_ack;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Testbench for reg_share_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_reg_share_arbiter;

    localparam int DW       = 8;
    localparam int MAXL     = 4;
`ifdef REG_SHARE_ARBITER_LOCK_EN
    localparam bit LOCK_ON  = 1'b1;
`else
    localparam bit LOCK_ON  = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req;
    logic [3:0]      we;
    logic [4*DW-1:0] wdata;
    logic [3:0]      lock;
    logic [3:0]      gnt;
    logic            busy;
    logic [DW-1:0]   q;
    logic [3:0]      wr_ack;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: granted requester (-1 when idle), pointer, register, ack, hold count.
    int            m_g;
    int            m_ptr;
    logic [DW-1:0] m_q;
    logic [3:0]    m_ack;
    int            m_cnt;

    reg_share_arbiter #(.DATA_W(DW), .MAX_LOCK(MAXL)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .wdata  (wdata),
`ifdef REG_SHARE_ARBITER_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .busy   (busy),
        .q      (q),
        .wr_ack (wr_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_gnt();
        return (m_g < 0) ? 4'b0000 : 4'(1 << m_g);
    endfunction

    // Advance one clock: model consumes the inputs seen at the edge; outputs sampled 1ns later.
    task automatic cycle();
        bit hold;
        @(posedge clk);
        if (reset) begin
            m_g = -1; m_ptr = 0; m_q = '0; m_ack = 4'b0000; m_cnt = 0;
        end else begin
            m_ack = 4'b0000;
            hold  = 1'b0;
            if (m_g >= 0) begin
                if (req[m_g] && we[m_g]) begin
                    m_q = wdata[m_g*DW +: DW];
                    m_ack[m_g] = 1'b1;
                end
                if (LOCK_ON && req[m_g] && lock[m_g] && (m_cnt + 1 < MAXL)) begin
                    hold = 1'b1;
                    m_cnt++;
                end else begin
                    m_ptr = (m_g + 1) % 4;
                end
            end
            if (!hold) begin
                m_g = -1;
                m_cnt = 0;
                for (int i = 0; i < 4; i++) begin
                    if (m_g < 0 && req[(m_ptr + i) % 4]) m_g = (m_ptr + i) % 4;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        req = 4'b0000; we = 4'b0000; wdata = '0; lock = 4'b0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({gnt, busy, q, wr_ack} !== {4'b0000, 1'b0, 8'h00, 4'b0000}) begin
                n_errors++;
                $display("FAIL reset_idle cyc%0d: gnt=%b busy=%b q=%h wr_ack=%b, want 0/0/00/0", k, gnt, busy, q, wr_ack);
            end
            cycle();
        end
    endtask

    task automatic test_single_write();
        do_reset();
        req = 4'b0100; we = 4'b0100; wdata = '0; wdata[2*DW +: DW] = 8'hA5;
        cycle();
        n_checks++;
        if (gnt !== 4'b0100 || busy !== 1'b1 || wr_ack !== 4'b0000) begin
            n_errors++;
            $display("FAIL single_grant: gnt=%b busy=%b wr_ack=%b, want 0100/1/0000", gnt, busy, wr_ack);
        end
        cycle();
        n_checks++;
        if (q !== 8'hA5 || wr_ack !== 4'b0100) begin
            n_errors++;
            $display("FAIL single_write: q=%h wr_ack=%b, want a5/0100", q, wr_ack);
        end
        req = 4'b0000; wdata[2*DW +: DW] = 8'h3C;
        cycle();
        n_checks++;
        if (wr_ack !== 4'b0000 || q !== 8'hA5 || gnt !== 4'b0000 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_release: wr_ack=%b q=%h gnt=%b busy=%b, want 0000/a5/0000/0", wr_ack, q, gnt, busy);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            exp = 4'(1 << (k % 4));
            n_checks++;
            if (gnt !== exp || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL rotation cyc%0d: gnt=%b busy=%b, want %b/1", k, gnt, busy, exp);
            end
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_reset_on_grant();
        do_reset();
        req = 4'b0010; we = 4'b0010; wdata[1*DW +: DW] = 8'h5A;
        cycle();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_errors++;
            $display("FAIL rog_grant: gnt=%b, want 0010", gnt);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_checks++;
        if (q !== 8'h00 || wr_ack !== 4'b0000 || gnt !== 4'b0000) begin
            n_errors++;
            $display("FAIL rog_suppress: q=%h wr_ack=%b gnt=%b, want 00/0000/0000", q, wr_ack, gnt);
        end
        req = 4'b1111; we = 4'b0000;
        cycle();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_errors++;
            $display("FAIL rog_ptr0: gnt=%b, want 0001", gnt);
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_no_write_wrap();
        do_reset();
        req = 4'b1000;
        cycle();
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_errors++;
            $display("FAIL wrap_grant3: gnt=%b, want 1000", gnt);
        end
        req = 4'b0000; we = 4'b1000; wdata[3*DW +: DW] = 8'hFF;
        cycle();
        n_checks++;
        if (q !== 8'h00 || wr_ack !== 4'b0000) begin
            n_errors++;
            $display("FAIL wrap_nowrite: q=%h wr_ack=%b, want 00/0000", q, wr_ack);
        end
        req = 4'b1001; we = 4'b0000;
        cycle();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_errors++;
            $display("FAIL wrap_next: gnt=%b, want 0001", gnt);
        end
        idle_inputs();
        cycle();
    endtask

`ifdef REG_SHARE_ARBITER_LOCK_EN
    task automatic test_lock();
        do_reset();
        req = 4'b0011; lock = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks++;
            if (gnt !== ((k < 4) ? 4'b0001 : 4'b0010)) begin
                n_errors++;
                $display("FAIL lock cyc%0d: gnt=%b, want %b", k, gnt, (k < 4) ? 4'b0001 : 4'b0010);
            end
        end
        idle_inputs();
        cycle();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 31) == 0);
            req   = 4'($urandom);
            we    = 4'($urandom);
            wdata = 32'($urandom);
            lock  = 4'($urandom);
            cycle();
            n_checks++;
            if (gnt !== m_gnt() || busy !== (m_g >= 0) || q !== m_q || wr_ack !== m_ack) begin
                n_errors++;
                $display("FAIL random cyc%0d: gnt=%b busy=%b q=%h wr_ack=%b, want %b/%b/%h/%b",
                         k, gnt, busy, q, wr_ack, m_gnt(), (m_g >= 0), m_q, m_ack);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_g = -1; m_ptr = 0; m_q = '0; m_ack = 4'b0000; m_cnt = 0;
        #2;
        test_reset();
        test_single_write();
        test_rotation();
        test_reset_on_grant();
        test_no_write_wrap();
`ifdef REG_SHARE_ARBITER_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
